// File: rtl/dcache_mem_adapter.sv
// dcache_mem_adapter
//   Bridges whole-line data cache requests onto a narrow word bus. Reads are
//   split into NUM_BEATS bus reads whose returned words are assembled into a
//   line and handed back with the request tag. Writes are split into one bus
//   write per beat that has at least one enabled byte; all-zero beats are
//   skipped. Only one line transaction is in flight at a time.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   mem_req_*             line request from the cache (valid/ready handshake)
//   mem_rsp_*             read line response to the cache (valid/ready)
//   bus_req_*             beat request to the bus (valid/ready, addr, we, be, wdata)
//   bus_rsp_valid/rdata   read beat return, in order, no backpressure
module dcache_mem_adapter #(
  parameter  int LINE_BYTES = 64,
  parameter  int BUS_BYTES  = 4,
  parameter  int LADDR_W    = 26,
  parameter  int TAG_W      = 8,
  localparam int NUM_BEATS  = LINE_BYTES / BUS_BYTES,
  localparam int BADDR_W    = LADDR_W + $clog2(LINE_BYTES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  input  logic                    mem_req_rw,
  input  logic [LINE_BYTES-1:0]   mem_req_byteen,
  input  logic [LADDR_W-1:0]      mem_req_addr,
  input  logic [8*LINE_BYTES-1:0] mem_req_data,
  input  logic [TAG_W-1:0]        mem_req_tag,
  output logic                    mem_rsp_valid,
  input  logic                    mem_rsp_ready,
  output logic [8*LINE_BYTES-1:0] mem_rsp_data,
  output logic [TAG_W-1:0]        mem_rsp_tag,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic                    bus_req_we,
  output logic [BADDR_W-1:0]      bus_req_addr,
  output logic [BUS_BYTES-1:0]    bus_req_be,
  output logic [8*BUS_BYTES-1:0]  bus_req_wdata,
  input  logic                    bus_rsp_valid,
  input  logic [8*BUS_BYTES-1:0]  bus_rsp_rdata
);

  localparam int BUS_W = 8 * BUS_BYTES;
  localparam int IDX_W = $clog2(NUM_BEATS);
  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        req_cnt, rsp_cnt;
  logic [IDX_W-1:0]        req_idx, rsp_idx;
  logic [LADDR_W-1:0]      addr_q;
  logic [TAG_W-1:0]        tag_q;
  logic [LINE_BYTES-1:0]   byteen_q;
  logic [8*LINE_BYTES-1:0] wdata_q;
  logic [8*LINE_BYTES-1:0] line_q;
  logic [BUS_BYTES-1:0]    be_slice;
  logic                    accept, beat_adv, capture;

  assign req_idx  = req_cnt[IDX_W-1:0];
  assign rsp_idx  = rsp_cnt[IDX_W-1:0];
  assign be_slice = byteen_q[req_idx*BUS_BYTES +: BUS_BYTES];

  // Byte address of the current beat: line address, beat index, then the
  // byte-within-word offset bits forced to zero.
  assign bus_req_addr  = BADDR_W'({addr_q, req_idx}) << OFF_W;
  assign bus_req_wdata = wdata_q[req_idx*BUS_W +: BUS_W];
  assign mem_rsp_data  = line_q;
  assign mem_rsp_tag   = tag_q;

  always_comb begin
    state_n       = state;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_we    = 1'b0;
    bus_req_be    = '1;
    accept        = 1'b0;
    beat_adv      = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          accept  = 1'b1;
          state_n = mem_req_rw ? WR : RD;
        end
      end
      RD: begin
        // Requests and returns run independently; returns keep arriving
        // after the last request has been issued.
        bus_req_valid = (req_cnt < BEATS_C);
        beat_adv      = bus_req_valid && bus_req_ready;
        capture       = bus_rsp_valid && (rsp_cnt < BEATS_C);
        if (rsp_cnt == BEATS_C) state_n = RSP;
      end
      RSP: begin
        mem_rsp_valid = 1'b1;
        if (mem_rsp_ready) state_n = IDLE;
      end
      WR: begin
        bus_req_we = 1'b1;
        bus_req_be = be_slice;
        if (be_slice != '0) begin
          bus_req_valid = 1'b1;
          beat_adv      = bus_req_ready;
        end else begin
          beat_adv = 1'b1;
        end
        if (beat_adv && (req_cnt == LAST_C)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q   <= mem_req_addr;
        tag_q    <= mem_req_tag;
        byteen_q <= mem_req_byteen;
        wdata_q  <= mem_req_data;
        req_cnt  <= '0;
        rsp_cnt  <= '0;
      end else begin
        if (beat_adv) req_cnt <= req_cnt + ONE_C;
        if (capture) begin
          line_q[rsp_idx*BUS_W +: BUS_W] <= bus_rsp_rdata;
          rsp_cnt <= rsp_cnt + ONE_C;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_mem_adapter.sv
// tb_dcache_mem_adapter
//   Bench for dcache_mem_adapter with 16-byte lines on a 4-byte bus. A bus
//   slave with its own byte memory answers beats; a line-level byte-array
//   reference predicts read lines and the expected list of bus beats.
module tb_dcache_mem_adapter;
  localparam int LB = 16;
  localparam int BB = 4;
  localparam int LW = 8;
  localparam int TW = 8;
  localparam int NB = LB / BB;
  localparam int AW = LW + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1;
  logic            mem_req_valid = 1'b0;
  logic            mem_req_ready;
  logic            mem_req_rw = 1'b0;
  logic [LB-1:0]   mem_req_byteen = '0;
  logic [LW-1:0]   mem_req_addr = '0;
  logic [8*LB-1:0] mem_req_data = '0;
  logic [TW-1:0]   mem_req_tag = '0;
  logic            mem_rsp_valid;
  logic            mem_rsp_ready = 1'b0;
  logic [8*LB-1:0] mem_rsp_data;
  logic [TW-1:0]   mem_rsp_tag;
  logic            bus_req_valid;
  logic            bus_req_ready = 1'b0;
  logic            bus_req_we;
  logic [AW-1:0]   bus_req_addr;
  logic [BB-1:0]   bus_req_be;
  logic [8*BB-1:0] bus_req_wdata;
  logic            bus_rsp_valid = 1'b0;
  logic [8*BB-1:0] bus_rsp_rdata = '0;

  dcache_mem_adapter #(
    .LINE_BYTES(LB),
    .BUS_BYTES (BB),
    .LADDR_W   (LW),
    .TAG_W     (TW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_req_byteen(mem_req_byteen),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_tag   (mem_req_tag),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_tag   (mem_rsp_tag),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_be    (bus_req_be),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [BB-1:0] be;
    logic [31:0]   wdata;
  } bus_t;

  typedef struct {
    bit           rw;
    logic [7:0]   addr;
    logic [7:0]   tag;
    logic [15:0]  be;
    logic [127:0] data;
    int           stall_beat;
    int           stall_cyc;
    int           rsp_stall;
    int           exp_nbus;
    int           exp_lat;
    bit           chk_rsp;
    logic [127:0] exp_rsp;
  } vec_t;

  bus_t       bus_log[$];
  bus_t       exp_bus[$];
  logic [31:0] rsp_q[$];
  logic [7:0] slave_mem [0:4095];
  logic [7:0] ref_mem   [0:4095];

  int checks = 0;
  int errors = 0;
  bit ready_rand = 0;
  bit rsp_rand = 0;
  int stall_beat = -1;
  int stall_cyc = 0;
  int stall_done = 0;
  int inject_stale = 0;
  bit prev_stalled = 0;
  bus_t prev_req;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_t cur_req();
    bus_t r;
    r.we    = bus_req_we;
    r.addr  = bus_req_addr;
    r.be    = bus_req_be;
    r.wdata = bus_req_we ? bus_req_wdata : 32'h0;
    return r;
  endfunction

  function automatic logic [127:0] ref_line(input logic [7:0] la);
    logic [127:0] r;
    logic [11:0]  ix;
    for (int b = 0; b < LB; b++) begin
      ix = {la, 4'(b)};
      r[8*b +: 8] = ref_mem[ix];
    end
    return r;
  endfunction

  // Bus slave: acts 1 time unit after each falling edge, so the main
  // sequence's input changes for this cycle are already visible.
  always @(negedge clk) begin
    logic [11:0] ix;
    logic [31:0] w;
    #1;
    if (inject_stale > 0) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = 32'hDEADBEEF;
      inject_stale--;
    end else if (rsp_q.size() > 0 && (!rsp_rand || $urandom_range(0, 1) == 1)) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = rsp_q.pop_front();
    end else begin
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = $urandom;
    end
    if (bus_req_valid && stall_beat >= 0 && bus_log.size() == stall_beat && stall_done < stall_cyc) begin
      bus_req_ready = 1'b0;
      stall_done++;
    end else if (ready_rand) begin
      bus_req_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bus_req_ready = 1'b1;
    end
    if (prev_stalled) begin
      chk("bus hold valid", 128'(bus_req_valid), 128'(1));
      chk("bus hold fields", 128'(cur_req()), 128'(prev_req));
    end
    prev_stalled = bus_req_valid && !bus_req_ready && !rst_i;
    prev_req     = cur_req();
    if (bus_req_valid && bus_req_ready && !rst_i) begin
      bus_log.push_back(cur_req());
      if (bus_req_we) begin
        for (int b = 0; b < BB; b++) begin
          ix = bus_req_addr + 12'(b);
          if (bus_req_be[b]) slave_mem[ix] = bus_req_wdata[8*b +: 8];
        end
      end else begin
        for (int b = 0; b < BB; b++) begin
          ix = bus_req_addr + 12'(b);
          w[8*b +: 8] = slave_mem[ix];
        end
        rsp_q.push_back(w);
      end
    end
  end

  task automatic do_txn(input bit rw, input logic [7:0] addr, input logic [7:0] tag,
                        input logic [15:0] be, input logic [127:0] data,
                        input int rsp_stall, output int lat, output logic [127:0] rsp);
    bus_t         e;
    logic [127:0] exp_line, d0;
    logic [7:0]   t0;
    logic [11:0]  ix;
    bit           got, saw_rsp;
    bus_log.delete();
    exp_bus.delete();
    exp_line = ref_line(addr);
    for (int i = 0; i < NB; i++) begin
      e.we    = rw;
      e.addr  = {addr, 2'(i), 2'b00};
      e.be    = rw ? be[4*i +: 4] : 4'hF;
      e.wdata = rw ? data[32*i +: 32] : 32'h0;
      if (!rw || e.be != 4'h0) exp_bus.push_back(e);
    end
    if (rw) begin
      for (int b = 0; b < LB; b++) begin
        ix = {addr, 4'(b)};
        if (be[b]) ref_mem[ix] = data[8*b +: 8];
      end
    end
    stall_done = 0;
    rsp = '0;
    @(negedge clk);
    chk("req ready before txn", 128'(mem_req_ready), 128'(1));
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_tag    = tag;
    mem_req_byteen = be;
    mem_req_data   = data;
    @(posedge clk);
    @(negedge clk);
    mem_req_valid = 1'b0;
    mem_req_data  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    got = 0;
    if (!rw) begin
      for (int c = 0; c < 300; c++) begin
        if (mem_rsp_valid) begin
          got = 1;
          break;
        end
        @(negedge clk);
        lat++;
      end
      chk("read rsp seen", 128'(got), 128'(1));
      if (got) begin
        d0 = mem_rsp_data;
        t0 = mem_rsp_tag;
        for (int s = 0; s < rsp_stall; s++) begin
          @(negedge clk);
          chk("rsp hold valid", 128'(mem_rsp_valid), 128'(1));
          chk("rsp hold data", mem_rsp_data, d0);
          chk("rsp hold tag", 128'(mem_rsp_tag), 128'(t0));
          chk("req ready in rsp", 128'(mem_req_ready), 128'(0));
        end
        rsp = mem_rsp_data;
        chk("read line data", mem_rsp_data, exp_line);
        chk("read tag", 128'(mem_rsp_tag), 128'(tag));
        mem_rsp_ready = 1'b1;
        @(negedge clk);
        mem_rsp_ready = 1'b0;
        chk("rsp drop after hs", 128'(mem_rsp_valid), 128'(0));
        chk("idle after rsp", 128'(mem_req_ready), 128'(1));
      end
    end else begin
      saw_rsp = 0;
      for (int c = 0; c < 300; c++) begin
        if (mem_req_ready) begin
          got = 1;
          break;
        end
        if (mem_rsp_valid) saw_rsp = 1;
        @(negedge clk);
        lat++;
      end
      chk("write done", 128'(got), 128'(1));
      chk("write no rsp", 128'(saw_rsp), 128'(0));
    end
    chk("bus beat count", 128'(bus_log.size()), 128'(exp_bus.size()));
    for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++)
      chk($sformatf("bus beat %0d", i), 128'(bus_log[i]), 128'(exp_bus[i]));
  endtask

  vec_t         vecs[7];
  int           lat;
  logic [127:0] rsp;
  logic [11:0]  ix;
  bit           reached;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ix = 12'(i);
      slave_mem[ix] = 8'(i * 37 + 11);
      ref_mem[ix]   = 8'(i * 37 + 11);
    end
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++) begin
        ix = 12'h100 + 12'(4 * k + b);
        slave_mem[ix] = 8'(17 * (k + 1));
        ref_mem[ix]   = 8'(17 * (k + 1));
      end

    //            rw addr   tag    byteen    data                                       sb sc rs nb lat chk exp_rsp
    vecs[0] = '{0, 8'h10, 8'h05, 16'h0000, 128'h0, -1, 0, 0, 4, 6, 1,
                128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{1, 8'h02, 8'h00, 16'hF0F0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, -1, 0, 0, 2, 4, 0, 128'h0};
    vecs[2] = '{1, 8'h03, 8'h00, 16'h0000, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, -1, 0, 0, 0, 4, 0, 128'h0};
    vecs[3] = '{0, 8'h02, 8'h77, 16'h0000, 128'h0, -1, 0, 0, 4, 6, 0, 128'h0};
    vecs[4] = '{0, 8'h05, 8'h3C, 16'h0000, 128'h0, 1, 3, 0, 4, 9, 0, 128'h0};
    vecs[5] = '{1, 8'h40, 8'h00, 16'hFFFF, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 3, 0, 4, 7, 0, 128'h0};
    vecs[6] = '{0, 8'h40, 8'hA5, 16'h0000, 128'h0, -1, 0, 5, 4, 6, 1,
                128'h01234567_89ABCDEF_FEDCBA98_76543210};

    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk("reset req ready", 128'(mem_req_ready), 128'(1));
    chk("reset rsp valid", 128'(mem_rsp_valid), 128'(0));
    chk("reset bus valid", 128'(bus_req_valid), 128'(0));

    for (int i = 0; i < 7; i++) begin
      stall_beat = vecs[i].stall_beat;
      stall_cyc  = vecs[i].stall_cyc;
      do_txn(vecs[i].rw, vecs[i].addr, vecs[i].tag, vecs[i].be, vecs[i].data,
             vecs[i].rsp_stall, lat, rsp);
      chk($sformatf("vec%0d bus count", i), 128'(bus_log.size()), 128'(vecs[i].exp_nbus));
      chk($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].exp_lat));
      if (vecs[i].chk_rsp) chk($sformatf("vec%0d line", i), rsp, vecs[i].exp_rsp);
    end
    stall_beat = -1;
    stall_cyc  = 0;

    // Abort a read after two beats have been issued.
    bus_log.delete();
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 8'h20;
    mem_req_tag   = 8'h99;
    @(posedge clk);
    @(negedge clk);
    mem_req_valid = 1'b0;
    reached = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus_log.size() >= 2) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort two beats issued", 128'(reached), 128'(1));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    rsp_q.delete();
    inject_stale = 3;
    chk("abort bus valid", 128'(bus_req_valid), 128'(0));
    chk("abort rsp valid", 128'(mem_rsp_valid), 128'(0));
    chk("abort req ready", 128'(mem_req_ready), 128'(1));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stale idle bus valid", 128'(bus_req_valid), 128'(0));
      chk("stale idle rsp valid", 128'(mem_rsp_valid), 128'(0));
      chk("stale idle ready", 128'(mem_req_ready), 128'(1));
    end
    do_txn(1'b0, 8'h20, 8'h5A, 16'h0, 128'h0, 0, lat, rsp);
    chk("post abort latency", 128'(lat), 128'(6));
    chk("post abort line", rsp, ref_line(8'h20));

    ready_rand = 1;
    rsp_rand   = 1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] be;
      be = 16'($urandom);
      if ($urandom_range(0, 4) == 0) be = '0;
      do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), be,
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 2)), lat, rsp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dcache_mem_adapter.md
DCACHE_MEM_ADAPTER -- requirements
Module: dcache_mem_adapter

Interface
REQ-001 Parameter LINE_BYTES, default 64, data cache line size in bytes (power of two, >= 2*BUS_BYTES).
REQ-002 Parameter BUS_BYTES, default 4, external bus word size in bytes (power of two).
REQ-003 Parameter LADDR_W, default 26, line-address width of the cache memory port.
REQ-004 Parameter TAG_W, default 8, memory tag width.
REQ-005 Derived: NUM_BEATS = LINE_BYTES/BUS_BYTES; BADDR_W = LADDR_W + log2(LINE_BYTES).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock; all state updates on its rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 mem_req_valid  in  1  cache line request valid.
REQ-010 mem_req_ready  out  1  adapter accepts a line request.
REQ-011 mem_req_rw  in  1  1 = write, 0 = read.
REQ-012 mem_req_byteen  in  LINE_BYTES  write byte enables.
REQ-013 mem_req_addr  in  LADDR_W  line address.
REQ-014 mem_req_data  in  8*LINE_BYTES  write line data.
REQ-015 mem_req_tag  in  TAG_W  request tag.
REQ-016 mem_rsp_valid  out  1  read line response valid.
REQ-017 mem_rsp_ready  in  1  cache accepts the response.
REQ-018 mem_rsp_data  out  8*LINE_BYTES  assembled read line.
REQ-019 mem_rsp_tag  out  TAG_W  tag of the completed read.
REQ-020 bus_req_valid / bus_req_ready  out / in  1 / 1  bus beat handshake.
REQ-021 bus_req_we  out  1  beat is a write.
REQ-022 bus_req_addr  out  BADDR_W  byte address {line_addr, beat_idx, log2(BUS_BYTES) zeros}.
REQ-023 bus_req_be  out  BUS_BYTES  beat byte enables (all ones for reads).
REQ-024 bus_req_wdata  out  8*BUS_BYTES  beat write data.
REQ-025 bus_rsp_valid  in  1  read beat returned; no backpressure, in request order.
REQ-026 bus_rsp_rdata  in  8*BUS_BYTES  read beat data.

Function
REQ-027 FSM states IDLE, RD, RSP, WR; one line transaction outstanding at a time.
REQ-028 mem_req_ready = 1 only in IDLE; on valid&ready, latch addr, tag, rw, byteen, data; go to RD (rw=0) or WR (rw=1); clear req_cnt and rsp_cnt.
REQ-029 RD: bus_req_valid=1, we=0, be all ones, beat_idx=req_cnt while req_cnt < NUM_BEATS; req_cnt increments on each bus handshake.
REQ-030 RD: each bus_rsp_valid writes bus_rsp_rdata into line slice rsp_cnt (beat 0 = LSBs) and increments rsp_cnt; responses may arrive in the same cycle as later requests.
REQ-031 RD -> RSP in the cycle after the NUM_BEATS-th response is captured.
REQ-032 RSP: mem_rsp_valid=1 with stable data and tag until mem_rsp_ready; on handshake -> IDLE.
REQ-033 WR: one beat examined per cycle at index req_cnt; beat with nonzero byteen slice issues bus_req_valid=1, we=1, be/wdata = that slice, and advances only on bus_req_ready; beat with all-zero byteen advances with no bus request.
REQ-034 WR -> IDLE after beat NUM_BEATS-1 is issued or skipped; writes produce no mem_rsp.
REQ-035 bus_req_valid, once asserted, holds with stable fields until bus_req_ready.
REQ-036 bus_rsp_valid outside RD is ignored; a new request is accepted no earlier than the cycle after returning to IDLE.
REQ-037 Read latency with bus_req_ready=1 and 1-cycle bus response: mem_rsp_valid NUM_BEATS+2 cycles after accept.

Reset
REQ-038 rst_i high: state=IDLE, counters=0, mem_req_ready=1 after reset, mem_rsp_valid=0, bus_req_valid=0; asserted mid-transaction aborts it with no further bus or mem output; latched data/tag need not be cleared.

Verification
REQ-039 LINE_BYTES=16, BUS_BYTES=4: read addr 0x10 tag 0x5, bus returns 0x11111111..0x44444444 -> bus addrs 0x100,0x104,0x108,0x10C; mem_rsp_data 0x44444444_33333333_22222222_11111111, tag 0x5.
REQ-040 Write addr 0x2, byteen 0xF0F0, data beats A..D -> exactly two bus writes, addrs 0x24 and 0x2C, be 0xF, no mem_rsp; byteen 0x0000 -> zero bus writes, IDLE after 4 cycles.
REQ-041 bus_req_ready low for 3 cycles on beat 1 -> bus_req_valid/addr/wdata stable throughout; beat order unchanged.
REQ-042 mem_rsp_ready held low 5 cycles in RSP -> mem_rsp_valid/data/tag stable, mem_req_ready=0 until handshake.
REQ-043 rst_i asserted after 2 read beats issued -> next cycle all valids 0, mem_req_ready=1; new read completes correctly, stale bus_rsp_valid in IDLE ignored.
